// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline plus memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 5
);
    // Handshake: a request transfers at a rising edge where req_valid && req_ready.
    // The requester holds opcode/addr/wdata stable while req_ready is low.
    // resp_valid is a one-cycle pulse with no back-pressure.
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              fault;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [2:0]        dbg_state;

    modport slave (
        input  req_valid, opcode, addr, wdata, mem_rdata,
        output req_ready, resp_valid, rdata, fault, mem_addr, mem_we, mem_wdata, dbg_state
    );

    modport master (
        output req_valid, opcode, addr, wdata, mem_rdata,
        input  req_ready, resp_valid, rdata, fault, mem_addr, mem_we, mem_wdata, dbg_state
    );
endinterface

// File: rtl/load_store_unit.sv
// MIPS memory-stage load/store unit: big-endian sub-word loads with extension,
// read-modify-write sub-word stores, and alignment/range fault detection.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    load_store_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_opcode;
    logic [1:0]        r_off;
    logic [15:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic        w_is_load;
    logic        w_is_sw;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic        w_accept;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merge;

    // Decode of the request currently presented on the bus.
    always_comb begin
        w_is_load    = 1'b0;
        w_is_sw      = 1'b0;
        w_is_mem     = 1'b0;
        w_misaligned = 1'b0;
        case (bus.opcode)
            OP_LB, OP_LBU: begin
                w_is_load = 1'b1;
                w_is_mem  = 1'b1;
            end
            OP_LH, OP_LHU: begin
                w_is_load    = 1'b1;
                w_is_mem     = 1'b1;
                w_misaligned = bus.addr[0];
            end
            OP_LW: begin
                w_is_load    = 1'b1;
                w_is_mem     = 1'b1;
                w_misaligned = |bus.addr[1:0];
            end
            OP_SB: begin
                w_is_mem = 1'b1;
            end
            OP_SH: begin
                w_is_mem     = 1'b1;
                w_misaligned = bus.addr[0];
            end
            OP_SW: begin
                w_is_sw      = 1'b1;
                w_is_mem     = 1'b1;
                w_misaligned = |bus.addr[1:0];
            end
            default: begin
                w_is_mem = 1'b0;
            end
        endcase
    end

    assign w_out_of_range = |bus.addr[31:ADDR_W+2];
    assign w_fault        = w_misaligned | w_out_of_range;
    assign w_accept       = (r_state == S_IDLE) & bus.req_valid & w_is_mem;

    // Big-endian lane select: offset 0 is the most significant byte/half.
    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0: w_byte = bus.mem_rdata[31:24];
            2'd1: w_byte = bus.mem_rdata[23:16];
            2'd2: w_byte = bus.mem_rdata[15:8];
            2'd3: w_byte = bus.mem_rdata[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = r_off[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

        w_load_val = 32'h0;
        case (r_opcode)
            OP_LB:   w_load_val = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_val = {24'h0, w_byte};
            OP_LH:   w_load_val = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_val = {16'h0, w_half};
            OP_LW:   w_load_val = bus.mem_rdata;
            default: w_load_val = 32'h0;
        endcase

        w_merge = bus.mem_rdata;
        if (r_opcode == OP_SB) begin
            case (r_off)
                2'd0: w_merge[31:24] = r_wdata[7:0];
                2'd1: w_merge[23:16] = r_wdata[7:0];
                2'd2: w_merge[15:8]  = r_wdata[7:0];
                2'd3: w_merge[7:0]   = r_wdata[7:0];
                default: w_merge = bus.mem_rdata;
            endcase
        end else if (r_off[1]) begin
            w_merge[15:0] = r_wdata;
        end else begin
            w_merge[31:16] = r_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_fault)        w_next = S_DONE;
                    else if (w_is_load) w_next = S_LOAD;
                    else if (w_is_sw)   w_next = S_WRITE;
                    else                w_next = S_RMW_RD;
                end
            end
            S_LOAD:   w_next = S_DONE;
            S_RMW_RD: w_next = S_WRITE;
            S_WRITE:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // rdata/fault only change on the edge entering DONE, so they hold between responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_opcode    <= 6'h0;
            r_off       <= 2'd0;
            r_wdata     <= 16'h0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_fault     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opcode   <= bus.opcode;
                        r_off      <= bus.addr[1:0];
                        r_wdata    <= bus.wdata[15:0];
                        r_mem_addr <= bus.addr[ADDR_W+1:2];
                        if (w_is_sw) begin
                            r_mem_wdata <= bus.wdata;
                        end
                        if (w_fault) begin
                            r_rdata <= 32'h0;
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_rdata <= w_load_val;
                    r_fault <= 1'b0;
                end
                S_RMW_RD: begin
                    r_mem_wdata <= w_merge;
                end
                S_WRITE: begin
                    r_rdata <= 32'h0;
                    r_fault <= 1'b0;
                end
                default: begin
                    r_fault <= r_fault;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) & ~reset;
    assign bus.resp_valid = (r_state == S_DONE) & ~reset;
    assign bus.mem_we     = (r_state == S_WRITE) & ~reset;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.rdata      = r_rdata;
    assign bus.fault      = r_fault;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-array memory, a byte-level reference
// model that schedules expected responses/writes, and a per-cycle compare process.
module tb_load_store_unit;
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADD = 6'b000000;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        fault;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_init;
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    resp_t       exp_q[$];
    wr_t         wr_q[$];
    int          cyc = 0;
    int          busy_start = 1;
    int          busy_end = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    load_store_unit_if #(.ADDR_W(5)) bus ();

    load_store_unit #(.ADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        if (i == 2) return 32'h8899AABB;
        if (i == 3) return 32'h11223344;
        return 32'hA000_0000 + 32'(i);
    endfunction

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: byte-addressed big-endian memory, accept edge n, response/write cycles.
    task automatic model_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                                input int n, input logic has_lit, input logic [31:0] lit);
        logic [31:0] word;
        logic [31:0] res;
        logic [31:0] nw;
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  wi;
        int          off;
        int          lat;
        bit          is_load;
        bit          is_store;
        bit          bad;
        resp_t       r;
        wr_t         w;
        wi       = a[6:2];
        off      = int'(a[1:0]);
        word     = ref_mem[wi];
        res      = 32'h0;
        is_load  = (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
        is_store = (op == SB) || (op == SH) || (op == SW);
        if (!is_load && !is_store) return;
        bad = (a > 32'h7F) || (((op == LW) || (op == SW)) && off != 0)
              || (((op == LH) || (op == LHU) || (op == SH)) && (off % 2) != 0);
        if (bad) begin
            lat = 0;
            r   = '{cyc: n, rdata: 32'h0, fault: 1'b1};
        end else if (is_load) begin
            b = word[8*(3-off) +: 8];
            h = word[8*(2-off) +: 16];
            case (op)
                LB:      res = 32'($signed(b));
                LBU:     res = 32'(b);
                LH:      res = 32'($signed(h));
                LHU:     res = 32'(h);
                default: res = word;
            endcase
            lat = 1;
            r   = '{cyc: n + 1, rdata: res, fault: 1'b0};
        end else begin
            nw = word;
            if (op == SW)      nw = wd;
            else if (op == SB) nw[8*(3-off) +: 8] = wd[7:0];
            else               nw[8*(2-off) +: 16] = wd[15:0];
            ref_mem[wi] = nw;
            lat = (op == SW) ? 1 : 2;
            w   = '{cyc: n + lat - 1, waddr: wi, wdata: nw};
            wr_q.push_back(w);
            r   = '{cyc: n + lat, rdata: 32'h0, fault: 1'b0};
        end
        exp_q.push_back(r);
        busy_start = n;
        busy_end   = n + lat;
        if (has_lit) check("model_lit", res, lit);
    endtask

    // Leaves req_valid high after acceptance so callers can chain requests.
    task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic has_lit, input logic [31:0] lit);
        int guard;
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.addr      = a;
        bus.wdata     = wd;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!bus.req_ready) begin
            flag("accept_timeout");
            return;
        end
        model_access(op, a, wd, cyc + 1, has_lit, lit);
        @(posedge clock);
    endtask

    task automatic wait_done();
        int guard;
        @(negedge clock);
        bus.req_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0 || !bus.req_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        #2;
        if (guard >= 20) flag("drain_timeout");
    endtask

    // Per-cycle comparison against the model's schedule.
    always @(negedge clock) begin
        #1;
        check("req_ready", 32'(bus.req_ready),
              32'(!reset && !(cyc >= busy_start && cyc <= busy_end)));
        while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            flag("resp_missing");
            void'(exp_q.pop_front());
        end
        if (bus.resp_valid) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                check("resp_rdata", bus.rdata, exp_q[0].rdata);
                check("resp_fault", 32'(bus.fault), 32'(exp_q[0].fault));
                void'(exp_q.pop_front());
            end else begin
                flag("resp_unexpected");
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            flag("resp_missing");
            void'(exp_q.pop_front());
        end
        while (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
            flag("write_missing");
            void'(wr_q.pop_front());
        end
        if (bus.mem_we) begin
            if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
                check("mem_addr", 32'(bus.mem_addr), 32'(wr_q[0].waddr));
                check("mem_wdata", bus.mem_wdata, wr_q[0].wdata);
                void'(wr_q.pop_front());
            end else begin
                flag("write_unexpected");
            end
        end else if (wr_q.size() != 0 && wr_q[0].cyc == cyc) begin
            flag("write_missing");
            void'(wr_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.opcode    = 6'h0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

        repeat (3) @(negedge clock);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clock);
        reset    = 1'b0;
        mem_init = 1'b0;

        // Loads with sign/zero extension.
        do_req(LB,  32'h0A, 32'h0, 1'b1, 32'hFFFFFFAA); wait_done();
        do_req(LBU, 32'h0A, 32'h0, 1'b1, 32'h000000AA); wait_done();
        do_req(LH,  32'h08, 32'h0, 1'b1, 32'hFFFF8899); wait_done();
        do_req(LHU, 32'h0A, 32'h0, 1'b1, 32'h0000AABB); wait_done();
        do_req(LW,  32'h08, 32'h0, 1'b1, 32'h8899AABB); wait_done();
        do_req(LB,  32'h0B, 32'h0, 1'b1, 32'hFFFFFFBB); wait_done();

        // Sub-word read-modify-write stores.
        do_req(SB, 32'h0D, 32'hFFFFFF55, 1'b0, 32'h0); wait_done();
        check("mem_w3_sb", mem[3], 32'h11553344);
        do_req(SH, 32'h0E, 32'h0000BEEF, 1'b0, 32'h0); wait_done();
        check("mem_w3_sh", mem[3], 32'h1155BEEF);
        do_req(LB, 32'h0C, 32'h0, 1'b1, 32'h00000011); wait_done();
        do_req(SB, 32'h7F, 32'h000000C3, 1'b0, 32'h0); wait_done();

        // Faults: misaligned and out of range.
        do_req(SW, 32'h06, 32'h12345678, 1'b1, 32'h0); wait_done();
        do_req(LH, 32'h03, 32'h0, 1'b1, 32'h0); wait_done();
        do_req(LW, 32'h80, 32'h0, 1'b1, 32'h0); wait_done();

        // Reset during the WRITE cycle of a store aborts it.
        begin
            logic [31:0] saved;
            saved = ref_mem[4];
            do_req(SW, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
            @(negedge clock);
            reset         = 1'b1;
            bus.req_valid = 1'b0;
            exp_q.delete();
            wr_q.delete();
            ref_mem[4] = saved;
            busy_start = 1;
            busy_end   = 0;
            @(negedge clock);
            reset = 1'b0;
            #1;
            check("abort_ready", 32'(bus.req_ready), 32'd1);
            check("abort_rdata", bus.rdata, 32'h0);
            check("abort_mem_w4", mem[4], 32'hA0000004);
        end

        // Back-to-back with req_valid held high, including a non-memory opcode.
        do_req(LW,  32'h08, 32'h0, 1'b1, 32'h8899AABB);
        do_req(SW,  32'h14, 32'h12345678, 1'b0, 32'h0);
        do_req(ADD, 32'h18, 32'hFFFFFFFF, 1'b0, 32'h0);
        wait_done();
        repeat (3) @(negedge clock);
        #2;
        check("mem_w5_sw", mem[5], 32'h12345678);

        for (int i = 0; i < 32; i++) check("mem_final", mem[i], ref_mem[i]);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("wr_q_empty", 32'(wr_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
